// File: rtl/panel_pkg.sv
// panel_pkg -- shared constants, types and helpers for the panel row receiver.
//
// Contents:
//   PANEL_WIDTH    default number of columns shifted per row
//   PANEL_ADDR_W   row address width ({D,C,B,A})
//   PANEL_COL_W    bits per column; COL_* give the bit order {R0,G0,B0,R1,G1,B1}
//   PIN_*          bit positions of each pin in the conditioned pin vector
//   panel_state_e  receiver FSM states
//   pack_col()     packs the six colour pins into one column word
package panel_pkg;

    localparam int PANEL_WIDTH  = 32;
    localparam int PANEL_ADDR_W = 4;
    localparam int PANEL_COL_W  = 6;

    // Per-column bit order: R0 in the MSB, B1 in the LSB
    localparam int COL_R0 = 5;
    localparam int COL_G0 = 4;
    localparam int COL_B0 = 3;
    localparam int COL_R1 = 2;
    localparam int COL_G1 = 1;
    localparam int COL_B1 = 0;

    // Layout of the conditioned pin vector
    localparam int PANEL_PIN_W  = 13;
    localparam int PIN_COL_LSB  = 0;
    localparam int PIN_ADDR_LSB = 6;
    localparam int PIN_CLK      = 10;
    localparam int PIN_STB      = 11;
    localparam int PIN_OE       = 12;

    // Pipeline reset value: OE (active-low) parks high so the panel reads as dark
    localparam logic [PANEL_PIN_W-1:0] PIN_RST = 13'h1000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } panel_state_e;

    function automatic logic [PANEL_COL_W-1:0] pack_col(
        input logic r0, input logic g0, input logic b0,
        input logic r1, input logic g1, input logic b1
    );
        logic [PANEL_COL_W-1:0] c;
        c         = 6'b000000;
        c[COL_R0] = r0;
        c[COL_G0] = g0;
        c[COL_B0] = b0;
        c[COL_R1] = r1;
        c[COL_G1] = g1;
        c[COL_B1] = b1;
        return c;
    endfunction

endpackage

// File: rtl/panel_rx_if.sv
// panel_rx_if -- bundle of the HUB75-style panel pins.
//
// Signals: PANEL_R0/G0/B0 (upper half colour), PANEL_R1/G1/B1 (lower half
// colour), PANEL_A..D (row address, A = LSB), PANEL_CLK (shift clock),
// PANEL_STB (latch strobe), PANEL_OE (output enable, active-low).
// Modports: master drives the pins (panel driver side), slave receives them.
interface panel_rx_if;

    logic PANEL_R0;
    logic PANEL_G0;
    logic PANEL_B0;
    logic PANEL_R1;
    logic PANEL_G1;
    logic PANEL_B1;
    logic PANEL_A;
    logic PANEL_B;
    logic PANEL_C;
    logic PANEL_D;
    logic PANEL_CLK;
    logic PANEL_STB;
    logic PANEL_OE;

    modport master (
        output PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1,
        output PANEL_A, PANEL_B, PANEL_C, PANEL_D,
        output PANEL_CLK, PANEL_STB, PANEL_OE
    );

    modport slave (
        input PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1,
        input PANEL_A, PANEL_B, PANEL_C, PANEL_D,
        input PANEL_CLK, PANEL_STB, PANEL_OE
    );

endinterface

// File: rtl/panel_rx_sync.sv
// panel_rx_sync -- common conditioning stage and edge detection for all panel pins.
//
// Every pin passes through the same register chain so that data, address,
// shift clock, strobe and OE stay cycle-aligned. With PANEL_RX_SYNC_EN defined
// the chain begins with a two-flop synchroniser, otherwise a single register.
// Edges (conditioned 1, previous 0) of PANEL_CLK and PANEL_STB are registered
// together with the data in one final output stage.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   pins             panel pins (panel_rx_if.slave)
//   col_o            conditioned colour column {R0,G0,B0,R1,G1,B1}
//   addr_o           conditioned row address {D,C,B,A}
//   oe_n_o           conditioned PANEL_OE
//   shift_edge_o     one-cycle pulse per PANEL_CLK rising edge
//   strobe_edge_o    one-cycle pulse per PANEL_STB rising edge
module panel_rx_sync
    import panel_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    panel_rx_if.slave                pins,
    output logic [PANEL_COL_W-1:0]   col_o,
    output logic [PANEL_ADDR_W-1:0]  addr_o,
    output logic                     oe_n_o,
    output logic                     shift_edge_o,
    output logic                     strobe_edge_o
);

    logic [PANEL_PIN_W-1:0] raw_s;

    // Gather the raw pins into one vector in package order
    always_comb begin
        raw_s = PIN_RST;
        raw_s[PIN_COL_LSB +: PANEL_COL_W] = pack_col(pins.PANEL_R0, pins.PANEL_G0, pins.PANEL_B0,
                                                     pins.PANEL_R1, pins.PANEL_G1, pins.PANEL_B1);
        raw_s[PIN_ADDR_LSB +: PANEL_ADDR_W] = {pins.PANEL_D, pins.PANEL_C, pins.PANEL_B, pins.PANEL_A};
        raw_s[PIN_CLK] = pins.PANEL_CLK;
        raw_s[PIN_STB] = pins.PANEL_STB;
        raw_s[PIN_OE]  = pins.PANEL_OE;
    end

`ifdef PANEL_RX_SYNC_EN
    localparam int STAGES = 2;
    logic [PANEL_PIN_W-1:0] meta_q;
    logic [PANEL_PIN_W-1:0] cond_q;

    // Two-flop synchroniser on every panel pin
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= PIN_RST;
            cond_q <= PIN_RST;
        end else begin
            meta_q <= raw_s;
            cond_q <= meta_q;
        end
    end
`else
    localparam int STAGES = 1;
    logic [PANEL_PIN_W-1:0] cond_q;

    // Single input register on every panel pin
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cond_q <= PIN_RST;
        end else begin
            cond_q <= raw_s;
        end
    end
`endif

    // fill_q[STAGES] rises once prev_q holds a real post-reset sample; until
    // then a pin that was already high at reset release must not look like an edge.
    logic [STAGES:0] fill_q;
    logic [1:0]      prev_q;        // {STB, CLK} history
    logic            shift_edge_s;
    logic            strobe_edge_s;

    logic [PANEL_COL_W-1:0]  col_q;
    logic [PANEL_ADDR_W-1:0] addr_q;
    logic                    oe_n_q;
    logic                    shift_edge_q;
    logic                    strobe_edge_q;

    // Rising-edge detection on the conditioned shift clock and strobe
    always_comb begin
        shift_edge_s  = 1'b0;
        strobe_edge_s = 1'b0;
        if (fill_q[STAGES]) begin
            shift_edge_s  = cond_q[PIN_CLK] & ~prev_q[0];
            strobe_edge_s = cond_q[PIN_STB] & ~prev_q[1];
        end else begin
            shift_edge_s  = 1'b0;
            strobe_edge_s = 1'b0;
        end
    end

    // Edge history, fill tracking and the aligned output stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q        <= '0;
            prev_q        <= 2'b00;
            col_q         <= '0;
            addr_q        <= '0;
            oe_n_q        <= 1'b1;
            shift_edge_q  <= 1'b0;
            strobe_edge_q <= 1'b0;
        end else begin
            fill_q        <= {fill_q[STAGES-1:0], 1'b1};
            prev_q        <= {cond_q[PIN_STB], cond_q[PIN_CLK]};
            col_q         <= cond_q[PIN_COL_LSB +: PANEL_COL_W];
            addr_q        <= cond_q[PIN_ADDR_LSB +: PANEL_ADDR_W];
            oe_n_q        <= cond_q[PIN_OE];
            shift_edge_q  <= shift_edge_s;
            strobe_edge_q <= strobe_edge_s;
        end
    end

    assign col_o         = col_q;
    assign addr_o        = addr_q;
    assign oe_n_o        = oe_n_q;
    assign shift_edge_o  = shift_edge_q;
    assign strobe_edge_o = strobe_edge_q;

endmodule

// File: rtl/panel_rx.sv
// panel_rx -- receives rows shifted into an LED matrix panel and reports each
// latched row.
//
// Optional feature: define PANEL_RX_SYNC_EN to add a two-flop synchroniser on
// every panel pin (PANEL_STB edge to row_valid = 4 cycles instead of 3).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   PANEL_R0/G0/B0       upper-half colour bits
//   PANEL_R1/G1/B1       lower-half colour bits
//   PANEL_A..D           row address, A = LSB
//   PANEL_CLK            shift clock (rising edge shifts one column)
//   PANEL_STB            latch strobe (rising edge latches the row)
//   PANEL_OE             output enable, active-low
//   row_valid            one-cycle pulse per latched row
//   row_addr             {D,C,B,A} at latch time
//   row_data             latched columns, 6 bits each, column 0 in the LSBs
//   row_short/row_over   fewer/more than WIDTH shift edges before the latch
//   lit                  registered inverse of the conditioned PANEL_OE
module panel_rx
    import panel_pkg::*;
#(
    parameter int WIDTH = PANEL_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PANEL_R0,
    input  logic                         PANEL_G0,
    input  logic                         PANEL_B0,
    input  logic                         PANEL_R1,
    input  logic                         PANEL_G1,
    input  logic                         PANEL_B1,
    input  logic                         PANEL_A,
    input  logic                         PANEL_B,
    input  logic                         PANEL_C,
    input  logic                         PANEL_D,
    input  logic                         PANEL_CLK,
    input  logic                         PANEL_STB,
    input  logic                         PANEL_OE,
    output logic                         row_valid,
    output logic [PANEL_ADDR_W-1:0]      row_addr,
    output logic [PANEL_COL_W*WIDTH-1:0] row_data,
    output logic                         row_short,
    output logic                         row_over,
    output logic                         lit
);

    localparam int DW    = PANEL_COL_W * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    panel_rx_if pins_if ();

    assign pins_if.PANEL_R0  = PANEL_R0;
    assign pins_if.PANEL_G0  = PANEL_G0;
    assign pins_if.PANEL_B0  = PANEL_B0;
    assign pins_if.PANEL_R1  = PANEL_R1;
    assign pins_if.PANEL_G1  = PANEL_G1;
    assign pins_if.PANEL_B1  = PANEL_B1;
    assign pins_if.PANEL_A   = PANEL_A;
    assign pins_if.PANEL_B   = PANEL_B;
    assign pins_if.PANEL_C   = PANEL_C;
    assign pins_if.PANEL_D   = PANEL_D;
    assign pins_if.PANEL_CLK = PANEL_CLK;
    assign pins_if.PANEL_STB = PANEL_STB;
    assign pins_if.PANEL_OE  = PANEL_OE;

    logic [PANEL_COL_W-1:0]  col_s;
    logic [PANEL_ADDR_W-1:0] addr_s;
    logic                    oe_n_s;
    logic                    shift_edge_s;
    logic                    strobe_edge_s;

    panel_rx_sync u_sync (
        .clk_i         (clk),
        .rst_i         (rst),
        .pins          (pins_if),
        .col_o         (col_s),
        .addr_o        (addr_s),
        .oe_n_o        (oe_n_s),
        .shift_edge_o  (shift_edge_s),
        .strobe_edge_o (strobe_edge_s)
    );

    panel_state_e            state_q;
    logic [DW-1:0]           shift_q;
    logic [DW-1:0]           shift_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    row_valid_q;
    logic [PANEL_ADDR_W-1:0] row_addr_q;
    logic [DW-1:0]           row_data_q;
    logic                    row_short_q;
    logic                    row_over_q;
    logic                    lit_q;

    // Next shift-register and edge-count values; a strobe in the same cycle
    // latches these, so a coincident shift edge is already included.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (shift_edge_s) begin
            shift_d = {shift_q[DW-PANEL_COL_W-1:0], col_s};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Row FSM, shift register, edge counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            row_valid_q <= 1'b0;
            row_addr_q  <= '0;
            row_data_q  <= '0;
            row_short_q <= 1'b0;
            row_over_q  <= 1'b0;
            lit_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            lit_q       <= ~oe_n_s;
            row_valid_q <= 1'b0;

            if (strobe_edge_s) begin
                // Overrun needs no special case: only the last WIDTH columns fit
                row_data_q  <= shift_d;
                row_addr_q  <= addr_s;
                row_short_q <= (cnt_d < CNT_FULL);
                row_over_q  <= (cnt_d > CNT_FULL);
                row_valid_q <= 1'b1;
                cnt_q       <= '0;
            end else begin
                cnt_q       <= cnt_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (shift_edge_s && !strobe_edge_s) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (strobe_edge_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign row_valid = row_valid_q;
    assign row_addr  = row_addr_q;
    assign row_data  = row_data_q;
    assign row_short = row_short_q;
    assign row_over  = row_over_q;
    assign lit       = lit_q;

endmodule

// File: doc/panel_rx.md
PANEL_RX -- requirements
Module: panel_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of columns per shifted row.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports PANEL_R0, PANEL_G0, PANEL_B0  input  1 each  upper-half colour bits.
REQ-005 SHALL have ports PANEL_R1, PANEL_G1, PANEL_B1  input  1 each  lower-half colour bits.
REQ-006 SHALL have ports PANEL_A, PANEL_B, PANEL_C, PANEL_D  input  1 each  row address, A = LSB.
REQ-007 SHALL have port PANEL_CLK  input  1  shift clock; data is taken on its rising edge.
REQ-008 SHALL have port PANEL_STB  input  1  latch strobe; row is latched on its rising edge.
REQ-009 SHALL have port PANEL_OE  input  1  output enable, active-low.
REQ-010 SHALL have port row_valid  output  1  one-cycle pulse when a new row is latched.
REQ-011 SHALL have port row_addr  output  4  {D,C,B,A} captured at latch time.
REQ-012 SHALL have port row_data  output  6*WIDTH  latched pixels, packed {R0,G0,B0,R1,G1,B1} per column, column 0 in the LSBs.
REQ-013 SHALL have port row_short  output  1  fewer than WIDTH shift edges preceded the last latch.
REQ-014 SHALL have port row_over  output  1  more than WIDTH shift edges preceded the last latch.
REQ-015 SHALL have port lit  output  1  registered inverse of conditioned PANEL_OE.

Function
REQ-016 SHALL pass all PANEL_* inputs through one common conditioning stage, so every signal sees identical latency.
REQ-017 SHALL detect an edge as conditioned value 1 with previous conditioned value 0, for both PANEL_CLK and PANEL_STB.
REQ-018 SHALL, on each PANEL_CLK edge, shift the six colour bits in at column 0 and move existing columns up by one; after WIDTH edges the first bit shifted sits at column WIDTH-1.
REQ-019 SHALL count shift edges in a counter saturating at WIDTH+1, cleared on every latch.
REQ-020 SHALL run FSM IDLE->SHIFT on the first shift edge after a latch and SHIFT->IDLE on a strobe edge; a strobe edge in IDLE latches with count 0.
REQ-021 SHALL, on a strobe edge, update row_data, row_addr, row_short (count<WIDTH) and row_over (count>WIDTH) on the following cycle and assert row_valid for exactly one cycle.
REQ-022 SHALL, when shift and strobe edges coincide, apply the shift first so the latched row includes the new bit and count includes that edge.
REQ-023 SHALL, on overrun, latch only the last WIDTH shifted columns.
REQ-024 SHALL hold row_* outputs stable between latches.
REQ-025 SHALL NOT recognise a strobe edge held high over consecutive cycles as more than one edge.

Reset
REQ-026 SHALL, when rst=1, clear the shift register, counter, edge history (previous values = 0), and set FSM=IDLE, row_valid=0, row_addr=0, row_data=0, row_short=0, row_over=0, lit=0.
REQ-027 SHALL, on reset mid-row, discard the partial row without asserting row_valid; an input already high at reset release SHALL NOT count as an edge.

Configuration
REQ-028 SHALL, with macro PANEL_RX_SYNC_EN defined, use a two-flop synchroniser per input; edge-to-row_valid latency is 4 cycles from the input change.
REQ-029 SHALL, without PANEL_RX_SYNC_EN, use a single register per input; latency is 3 cycles.

Structure
REQ-030 SHALL take WIDTH default, address width (4) and per-column bit order constants from shared package panel_pkg.
REQ-031 SHALL put input conditioning and edge detection in sub-module panel_rx_sync.

Verification
REQ-032 SHALL cover: 32 shift edges with column pattern 0b100100, then strobe with ABCD=0 -> one row_valid, row_data all 0x24 per column, row_short=0, row_over=0.
REQ-033 SHALL cover: 512 shift edges with constant R0=R1=1 per strobe period, STB edge with addr 0 -> row_over=1, row_data red on all columns.
REQ-034 SHALL cover: 10 shift edges then strobe with addr 5 -> row_short=1, row_addr=5, columns 0..9 hold the shifted data.
REQ-035 SHALL cover: strobe coincident with the 32nd shift edge -> row_over=0 and row_short=0, column 0 holds the final bit.
REQ-036 SHALL cover: rst pulsed after 16 shift edges, then 32 edges and a strobe -> no row_valid before the strobe, clean row.
REQ-037 SHALL cover: PANEL_OE=0 -> lit=1 after the configured latency; run with and without PANEL_RX_SYNC_EN.
